// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem req/gnt/rvalid bus, instruction output handshake and redirect input.
// Signals: imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata (memory side),
// instr_valid/instr/instr_pc/instr_ready (decode side), redirect_valid/redirect_pc/misaligned.
// master = fetch unit, slave = memory plus decode environment.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misaligned;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, misaligned,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, misaligned,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC sequencer, single-outstanding imem fetch, FIFO buffer, redirect flush.
// Ports: clk, reset (async active-high), bus (instr_fetch_unit_if.master).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic             clk,
  input logic             reset,
  instr_fetch_unit_if.master bus
);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_t;
  state_t        state;
  logic [31:0]   fetch_pc, req_pc, target;
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          redir, gnt_ok, push, pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign redir           = bus.redirect_valid;
  assign target          = {bus.redirect_pc[31:2], 2'b00};
  assign bus.imem_req    = state == FETCH && count < CW'(FIFO_DEPTH);
  assign bus.imem_addr   = fetch_pc;
  assign gnt_ok          = bus.imem_req && bus.imem_gnt;
  // a redirect kills both the returning word and any same-cycle pop
  assign push            = state == WAIT && bus.imem_rvalid && !redir;
  assign pop             = bus.instr_valid && bus.instr_ready && !redir;
  assign bus.instr_valid = count != '0;
  assign bus.instr       = bus.instr_valid ? fifo_data[head] : 32'h0000_0013;
  assign bus.instr_pc    = bus.instr_valid ? fifo_pc[head] : '0;
  always_ff @(posedge clk)
    if (push) begin
      fifo_pc[tail]   <= req_pc;
      fifo_data[tail] <= bus.imem_rdata;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state          <= FETCH;
      fetch_pc       <= RESET_PC;
      req_pc         <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      bus.misaligned <= 1'b0;
    end else begin
      bus.misaligned <= redir && |bus.redirect_pc[1:0];
      if (redir) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= target;
      end else begin
        if (push) tail <= nxt(tail);
        if (pop) head <= nxt(head);
        count <= count + CW'(push) - CW'(pop);
      end
      case (state)
        // a grant in a redirect cycle leaves a stale response in flight: drain it
        FETCH: if (redir) state <= gnt_ok ? DRAIN : FETCH;
               else if (gnt_ok) begin
                 req_pc   <= fetch_pc;
                 fetch_pc <= fetch_pc + 32'd4;
                 state    <= WAIT;
               end
        WAIT:  if (bus.imem_rvalid) state <= FETCH;
               else if (redir) state <= DRAIN;
        DRAIN: if (bus.imem_rvalid) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
endmodule
